// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for clock lock plus a hold time, then releases
// STAGES ordered reset domains one at a time, each gated on the previous domain's ready.
module reset_sequencer #(
    parameter int unsigned STAGES      = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_locked,
    input  logic                           i_request,
    input  logic [STAGES-1:0]              i_ready,
    output logic [STAGES-1:0]              o_reset,
    output logic                           o_busy,
    output logic                           o_fault,
    output logic [$clog2(STAGES+1)-1:0]    o_stage
);

    localparam int unsigned SW      = $clog2(STAGES + 1);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_HOLD      = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_stage;
    logic [SW-1:0]     w_stage_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic [STAGES-1:0] r_reset;
    logic [STAGES-1:0] w_reset_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_fault;
    logic              w_fault_nxt;
    logic              w_ready_cur;
    logic              w_restart;

    // State, counter and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_WAIT_LOCK;
            r_stage <= '0;
            r_count <= '0;
            r_reset <= '1;
            r_busy  <= 1'b1;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_count <= w_count_nxt;
            r_reset <= w_reset_nxt;
            r_busy  <= w_busy_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Next state: lock loss beats request, request beats ready/timeout/hold expiry
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_restart   = 1'b0;
        w_ready_cur = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (r_stage == SW'(k)) begin
                w_ready_cur = i_ready[k];
            end
        end

        case (r_state)
            S_WAIT_LOCK: begin
                w_stage_nxt = '0;
                if (i_locked) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!i_locked) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (i_request) begin
                    w_restart = 1'b1;
                end else if (r_count == CW'(HOLD_CYCLES - 1)) begin
                    w_state_nxt = S_RELEASE;
                    w_stage_nxt = '0;
                end
            end
            S_RELEASE: begin
                if (!i_locked) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_stage_nxt = '0;
                end else if (i_request) begin
                    w_state_nxt = S_HOLD;
                    w_stage_nxt = '0;
                end else if (w_ready_cur) begin
                    w_stage_nxt = r_stage + SW'(1);
                    if (r_stage == SW'(STAGES - 1)) begin
                        w_state_nxt = S_RUN;
                    end
                end else if (r_count == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_RUN: begin
                if (!i_locked) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_stage_nxt = '0;
                end else if (i_request) begin
                    w_state_nxt = S_HOLD;
                    w_stage_nxt = '0;
                end
            end
            S_FAULT: begin
                if (i_request) begin
                    w_state_nxt = i_locked ? S_HOLD : S_WAIT_LOCK;
                    w_stage_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_stage_nxt = '0;
            end
        endcase

        // Shared counter restarts on any state or stage change
        if (w_restart || (w_state_nxt != r_state) || (w_stage_nxt != r_stage)) begin
            w_count_nxt = '0;
        end else if (r_count != {CW{1'b1}}) begin
            w_count_nxt = r_count + CW'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Outputs decoded from the upcoming state so they register on the same edge
    always_comb begin
        w_reset_nxt = '1;
        w_busy_nxt  = 1'b1;
        w_fault_nxt = 1'b0;
        case (w_state_nxt)
            S_RELEASE: begin
                for (int j = 0; j < STAGES; j++) begin
                    w_reset_nxt[j] = (SW'(j) > w_stage_nxt);
                end
            end
            S_RUN: begin
                w_reset_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
            S_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_reset_nxt = '1;
            end
        endcase
    end

    assign o_reset = r_reset;
    assign o_busy  = r_busy;
    assign o_fault = r_fault;
    assign o_stage = r_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized
// stimulus compared against an edge-timestamp reference model.
module tb_reset_sequencer;

    localparam int unsigned STAGES = 3;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned TMO    = 8;
    localparam int unsigned SW     = $clog2(STAGES + 1);

    localparam int M_WAIT  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_SEQ   = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              locked;
    logic              req;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] o_reset;
    logic              o_busy;
    logic              o_fault;
    logic [SW-1:0]     o_stage;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    int m_mode       = M_WAIT;
    int m_k          = 0;
    int m_hold_start = 0;
    int m_rel_edge   = 0;

    reset_sequencer #(
        .STAGES      (STAGES),
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_locked  (locked),
        .i_request (req),
        .i_ready   (ready),
        .o_reset   (o_reset),
        .o_busy    (o_busy),
        .o_fault   (o_fault),
        .o_stage   (o_stage)
    );

    always #5 clk = ~clk;

    // Reference: tracks how many domains are released and when phases began
    function automatic void model_update();
        if (rst) begin
            m_mode = M_WAIT;
            m_k    = 0;
        end else begin
            case (m_mode)
                M_WAIT: if (locked) begin m_mode = M_HOLD; m_hold_start = edge_n; end
                M_HOLD: begin
                    if (!locked) m_mode = M_WAIT;
                    else if (req) m_hold_start = edge_n;
                    else if (edge_n - m_hold_start == int'(HOLD)) begin
                        m_mode = M_SEQ; m_k = 0; m_rel_edge = edge_n;
                    end
                end
                M_SEQ: begin
                    if (!locked) begin m_mode = M_WAIT; m_k = 0; end
                    else if (req) begin m_mode = M_HOLD; m_k = 0; m_hold_start = edge_n; end
                    else if (ready[m_k]) begin
                        m_k++;
                        m_rel_edge = edge_n;
                        if (m_k == int'(STAGES)) m_mode = M_RUN;
                    end else if (edge_n - m_rel_edge == int'(TMO)) m_mode = M_FAULT;
                end
                M_RUN: begin
                    if (!locked) m_mode = M_WAIT;
                    else if (req) begin m_mode = M_HOLD; m_hold_start = edge_n; end
                end
                default: begin
                    if (req) begin
                        m_k = 0;
                        if (locked) begin m_mode = M_HOLD; m_hold_start = edge_n; end
                        else m_mode = M_WAIT;
                    end
                end
            endcase
        end
    endfunction

    function automatic logic [STAGES+SW+1:0] model_out();
        int full;
        int rv;
        int st;
        full = (1 << STAGES) - 1;
        rv   = full;
        st   = 0;
        if (m_mode == M_SEQ) begin
            rv = full & ~((1 << (m_k + 1)) - 1);
            st = m_k;
        end else if (m_mode == M_RUN) begin
            rv = 0;
            st = STAGES;
        end else if (m_mode == M_FAULT) begin
            st = m_k;
        end
        return {STAGES'(rv), (m_mode != M_RUN), (m_mode == M_FAULT), SW'(st)};
    endfunction

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_update();
        #1;
    endtask

    // Reset, lock, wait out the hold: returns the edge at which o_reset[0] fell
    task automatic bring_up(output int t0);
        rst = 1'b1; locked = 1'b0; req = 1'b0; ready = '0;
        step(); step();
        rst = 1'b0;
        step();
        locked = 1'b1;
        step();
        repeat (HOLD) step();
        t0 = edge_n;
    endtask

    task automatic test_reset();
        rst = 1'b1; locked = 1'b1; req = 1'b1; ready = '1;
        step();
        checks++;
        if ({o_reset, o_busy, o_fault, o_stage} !== {3'b111, 1'b1, 1'b0, SW'(0)}) begin
            failures++;
            $display("FAIL reset_state: got reset=%b busy=%b fault=%b stage=%0d, want 111 1 0 0",
                     o_reset, o_busy, o_fault, o_stage);
        end
        rst = 1'b0; locked = 1'b0; req = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_reset, o_busy} !== {3'b111, 1'b1}) begin
            failures++;
            $display("FAIL wait_lock: got reset=%b busy=%b, want 111 1", o_reset, o_busy);
        end
    endtask

    task automatic test_nominal();
        logic [STAGES-1:0] exp_r;
        rst = 1'b1; locked = 1'b0; req = 1'b0; ready = '0;
        step(); step();
        rst = 1'b0;
        step();
        locked = 1'b1;
        step();
        for (int i = 1; i <= 12; i++) begin
            ready = {(i >= 10), (i >= 8), (i >= 6)};
            step();
            exp_r = (i < 4) ? 3'b111 : (i < 6) ? 3'b110 : (i < 8) ? 3'b100 : 3'b000;
            checks++;
            if ({o_reset, o_busy} !== {exp_r, (i < 10)}) begin
                failures++;
                $display("FAIL nominal_edge%0d: got reset=%b busy=%b, want %b %b",
                         i, o_reset, o_busy, exp_r, (i < 10));
            end
        end
        ready = '0;
        step();
        checks++;
        if ({o_reset, o_busy, o_stage} !== {3'b000, 1'b0, SW'(3)}) begin
            failures++;
            $display("FAIL run_ignores_ready: got reset=%b busy=%b stage=%0d, want 000 0 3",
                     o_reset, o_busy, o_stage);
        end
    endtask

    task automatic test_fault_request();
        int t0;
        bring_up(t0);
        ready = 3'b001;
        step();
        repeat (TMO - 1) step();
        checks++;
        if ({o_reset, o_fault, o_stage} !== {3'b100, 1'b0, SW'(1)}) begin
            failures++;
            $display("FAIL pre_timeout: got reset=%b fault=%b stage=%0d, want 100 0 1",
                     o_reset, o_fault, o_stage);
        end
        step();
        checks++;
        if ({o_reset, o_busy, o_fault, o_stage} !== {3'b111, 1'b1, 1'b1, SW'(1)}) begin
            failures++;
            $display("FAIL timeout_fault: got reset=%b busy=%b fault=%b stage=%0d, want 111 1 1 1",
                     o_reset, o_busy, o_fault, o_stage);
        end
        locked = 1'b0;
        step();
        checks++;
        if ({o_fault, o_stage} !== {1'b1, SW'(1)}) begin
            failures++;
            $display("FAIL fault_keeps_on_unlock: got fault=%b stage=%0d, want 1 1", o_fault, o_stage);
        end
        locked = 1'b1; req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if ({o_reset, o_busy, o_fault, o_stage} !== {3'b111, 1'b1, 1'b0, SW'(0)}) begin
            failures++;
            $display("FAIL fault_request: got reset=%b busy=%b fault=%b stage=%0d, want 111 1 0 0",
                     o_reset, o_busy, o_fault, o_stage);
        end
        repeat (HOLD - 1) step();
        checks++;
        if (o_reset !== 3'b111) begin
            failures++;
            $display("FAIL restart_hold: got reset=%b, want 111", o_reset);
        end
        step();
        checks++;
        if (o_reset !== 3'b110) begin
            failures++;
            $display("FAIL restart_release0: got reset=%b, want 110", o_reset);
        end
    endtask

    task automatic test_timeout_boundary();
        int t0;
        bring_up(t0);
        repeat (TMO - 1) step();
        ready = 3'b001;
        step();
        checks++;
        if ({o_reset, o_fault, o_stage} !== {3'b100, 1'b0, SW'(1)}) begin
            failures++;
            $display("FAIL ready_on_timeout_edge: got reset=%b fault=%b stage=%0d, want 100 0 1",
                     o_reset, o_fault, o_stage);
        end
    endtask

    task automatic test_lock_loss();
        int t0;
        bring_up(t0);
        ready = '1;
        repeat (3) step();
        checks++;
        if ({o_reset, o_busy, o_stage} !== {3'b000, 1'b0, SW'(3)}) begin
            failures++;
            $display("FAIL reach_run: got reset=%b busy=%b stage=%0d, want 000 0 3",
                     o_reset, o_busy, o_stage);
        end
        locked = 1'b0;
        step();
        checks++;
        if ({o_reset, o_busy, o_stage} !== {3'b111, 1'b1, SW'(0)}) begin
            failures++;
            $display("FAIL lock_loss: got reset=%b busy=%b stage=%0d, want 111 1 0",
                     o_reset, o_busy, o_stage);
        end
        locked = 1'b1;
        step();
        repeat (HOLD - 1) step();
        checks++;
        if (o_reset !== 3'b111) begin
            failures++;
            $display("FAIL relock_hold: got reset=%b, want 111", o_reset);
        end
        step();
        checks++;
        if (o_reset !== 3'b110) begin
            failures++;
            $display("FAIL relock_release0: got reset=%b, want 110", o_reset);
        end
        repeat (3) step();
        checks++;
        if ({o_reset, o_busy} !== {3'b000, 1'b0}) begin
            failures++;
            $display("FAIL relock_run: got reset=%b busy=%b, want 000 0", o_reset, o_busy);
        end
    endtask

    task automatic test_request_held();
        int t0;
        bring_up(t0);
        ready = 3'b001;
        step();
        req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({o_reset, o_busy, o_stage} !== {3'b111, 1'b1, SW'(0)}) begin
                failures++;
                $display("FAIL request_held_%0d: got reset=%b busy=%b stage=%0d, want 111 1 0",
                         i, o_reset, o_busy, o_stage);
            end
        end
        req = 1'b0;
        repeat (HOLD - 1) step();
        checks++;
        if (o_reset !== 3'b111) begin
            failures++;
            $display("FAIL request_hold_count: got reset=%b, want 111", o_reset);
        end
        step();
        checks++;
        if (o_reset !== 3'b110) begin
            failures++;
            $display("FAIL request_release0: got reset=%b, want 110", o_reset);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bring_up(t0);
        ready = 3'b011;
        step(); step();
        checks++;
        if ({o_reset, o_busy, o_stage} !== {3'b000, 1'b1, SW'(2)}) begin
            failures++;
            $display("FAIL release2: got reset=%b busy=%b stage=%0d, want 000 1 2",
                     o_reset, o_busy, o_stage);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({o_reset, o_busy, o_fault, o_stage} !== {3'b111, 1'b1, 1'b0, SW'(0)}) begin
            failures++;
            $display("FAIL reset_mid: got reset=%b busy=%b fault=%b stage=%0d, want 111 1 0 0",
                     o_reset, o_busy, o_fault, o_stage);
        end
    endtask

    task automatic test_random();
        logic [STAGES+SW+1:0] exp_v;
        int errs;
        errs = 0;
        rst = 1'b1; locked = 1'b0; req = 1'b0; ready = '0;
        step();
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 299) == 0);
            locked = ($urandom_range(0, 39) != 0);
            req    = ($urandom_range(0, 34) == 0);
            for (int b = 0; b < STAGES; b++) ready[b] = ($urandom_range(0, 2) == 0);
            step();
            exp_v = model_out();
            checks++;
            if ({o_reset, o_busy, o_fault, o_stage} !== exp_v) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got reset=%b busy=%b fault=%b stage=%0d, want %b",
                             c, o_reset, o_busy, o_fault, o_stage, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; locked = 1'b0; req = 1'b0; ready = '0;
        test_reset();
        test_nominal();
        test_fault_request();
        test_timeout_boundary();
        test_lock_loss();
        test_request_held();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences the release of a power-on reset across `STAGES` ordered reset domains (clock/PLL, memory controller, bus fabric, CPU, …). The block waits for clock lock and a fixed hold time, then deasserts each domain's reset in order. It advances to the next domain only after the current one reports ready, and flags a fault on timeout. It sits at the top of the SoC, replacing the per-domain fixed-length reset stretchers, and also handles software-requested re-sequencing.

## Interface
- `STAGES`, 4, number of ordered reset domains (1..8).
- `HOLD_CYCLES`, 16, cycles all resets stay asserted after lock is first seen (≥1).
- `TIMEOUT`, 1024, maximum cycles to wait for a stage's ready after releasing it (≥1).

Ports:
- `i_clock`  in  1  sole clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_locked`  in  1  PLL/clock-good, already synchronised to `i_clock`.
- `i_request`  in  1  soft re-sequence request, level or pulse, sampled each edge.
- `i_ready`  in  STAGES  per-domain ready, synchronised; bit k is meaningful only while `o_reset[k]`=0.
- `o_reset`  out  STAGES  per-domain reset, active high, registered.
- `o_busy`  out  1  high whenever not in RUN.
- `o_fault`  out  1  high in FAULT.
- `o_stage`  out  $clog2(STAGES+1)  stage being awaited; STAGES in RUN; failing stage in FAULT.

## Operation
- States: WAIT_LOCK, HOLD, RELEASE(k), RUN, FAULT. One shared counter, width $clog2(max(HOLD_CYCLES,TIMEOUT)+1), saturating, cleared on every state change.
- Reset / priority per edge: `i_reset` > lock loss > `i_request` > ready / timeout / hold expiry.
- `i_reset`=1: state WAIT_LOCK, `o_reset`=all ones, `o_busy`=1, `o_fault`=0, `o_stage`=0, counter=0. Applies identically mid-sequence.
- WAIT_LOCK: all resets asserted. `i_locked`=1 → HOLD.
- HOLD: all resets asserted. Counter counts up. After HOLD_CYCLES cycles in HOLD → RELEASE(0), and `o_reset[0]` is cleared on that same edge.
- RELEASE(k): `o_reset[j]`=0 for j≤k, 1 for j>k. `o_stage`=k.
  - `i_ready[k]`=1 → RELEASE(k+1), clearing `o_reset[k+1]`; if k=STAGES-1 → RUN.
  - Otherwise counter increments; counter reaching TIMEOUT with ready still low → FAULT.
  - Ready sampled on the same edge as the timeout wins.
- RUN: `o_busy`=0, `o_stage`=STAGES. Deassertion of `i_ready` is ignored.
- FAULT: all resets asserted, `o_fault`=1, `o_stage` holds the failing k. Only `i_request` (→HOLD if locked, else WAIT_LOCK) or `i_reset` leaves FAULT.
- Lock loss (`i_locked`=0) in HOLD, RELEASE, RUN → WAIT_LOCK with all resets asserted on that edge. Lock loss in FAULT is ignored (FAULT is retained).
- `i_request`=1 in HOLD, RELEASE or RUN with lock high → HOLD, all resets asserted, counter cleared. A held-high request keeps restarting HOLD; the sequence proceeds only after request drops.
- `i_ready` bits of domains still in reset are never sampled.

## Timing
- All outputs are registered and change only on rising `i_clock`; no combinational input→output path.
- Lock sampled high at edge E (in WAIT_LOCK) → HOLD from E. `o_reset[0]` falls at edge E+HOLD_CYCLES.
- `o_reset[k]` falls at edge T. `i_ready[k]` first sampled high at edge T+n (n≥1) → `o_reset[k+1]` falls at T+n. Minimum stage-to-stage spacing is 1 cycle.
- Timeout: ready low at edges T+1..T+TIMEOUT → FAULT at edge T+TIMEOUT.
- Lock loss, request and `i_reset` take effect on the edge they are sampled (1-edge latency to outputs).

## Test plan
- STAGES=3, HOLD_CYCLES=4, TIMEOUT=8. Release `i_reset`, lock high at edge 10, each ready asserted 2 cycles after its reset falls → `o_reset` 111→110 at edge 14, 100 at 16, 000 at 18; `o_busy` falls at 20, `o_stage`=3.
- Same setup, `i_ready[1]` never asserted → FAULT 8 edges after `o_reset[1]` falls; `o_reset`=111, `o_fault`=1, `o_stage`=1. Then pulse `i_request` → HOLD, `o_fault`=0, sequence restarts.
- `i_ready[0]` asserted exactly on edge T+8 → RELEASE(1), no fault.
- Drop `i_locked` for 1 cycle while in RUN → `o_reset`=111 on the next edge, WAIT_LOCK. On relock, a full sequence repeats with the same edge offsets.
- `i_request` held high 5 cycles during RELEASE(1) → resets reassert. HOLD counting starts only after request falls; `o_reset[0]` falls 4 edges later.
- Assert `i_reset` during RELEASE(2) → next edge `o_reset`=111, `o_busy`=1, `o_fault`=0, `o_stage`=0.
